// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: scoreboard of EX/MEM/WB destinations driving
// decode bubbles, fetch hold, IF-ID flush and the global freeze on data-cache misses.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_RegWrt,
  input  logic [2:0]       id_RD,
  input  logic             id_mem,
  input  logic             id_halt,
  input  logic             ex_branch,
  input  logic             Done_DM,
  output logic             NOP_mech,
  output logic             stall_fetch,
  output logic             flush_ifid,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 3;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             mem;
    logic             halt;
  } sb_entry_t;

  typedef enum logic [1:0] {RUN, MWAIT, HALT} state_t;

  state_t    state_q, state_d;
  sb_entry_t ex_q, mem_q, wb_q, ex_d;
  logic      in_halt, mem_busy, raw;

  // WB is excluded: the register file bypasses its write to the ID read.
  function automatic logic match(input logic [REG_W-1:0] r,
                                 input sb_entry_t ex, input sb_entry_t mem);
    return (ex.v && ex.rd == r) || (mem.v && mem.rd == r);
  endfunction

  // Next state, stall/flush decisions and the entry shifted into EX.
  always_comb begin
    state_d     = state_q;
    NOP_mech    = 1'b0;
    stall_fetch = 1'b0;
    flush_ifid  = 1'b0;
    freeze      = 1'b0;
    halted      = 1'b0;
    ex_d        = '0;

    in_halt  = (state_q == HALT) || wb_q.halt;
    mem_busy = mem_q.mem && !Done_DM;
    raw      = (id_use_rs && match(id_rs, ex_q, mem_q)) ||
               (id_use_rt && match(id_rt, ex_q, mem_q));

    case (state_q)
      RUN: begin
        if (wb_q.halt)    state_d = HALT;
        else if (mem_busy) state_d = MWAIT;
      end
      MWAIT: begin
        if (wb_q.halt)    state_d = HALT;
        else if (Done_DM) state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase

    if (in_halt) begin
      freeze      = 1'b1;
      stall_fetch = 1'b1;
      halted      = 1'b1;
    end else if (mem_busy) begin
      freeze      = 1'b1;
      stall_fetch = 1'b1;
    end else if (ex_branch) begin
      flush_ifid  = 1'b1;
      NOP_mech    = 1'b1;
    end else if (raw) begin
      NOP_mech    = 1'b1;
      stall_fetch = 1'b1;
    end

    if (!NOP_mech && !ex_branch) begin
      ex_d.v    = id_RegWrt;
      ex_d.rd   = id_RD;
      ex_d.mem  = id_mem;
      ex_d.halt = id_halt;
    end
  end

  // Scoreboard shift, FSM state and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (stall_fetch && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW bubbles, cache-miss freeze, branch squash, HALT.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [2:0]       id_rs, id_rt, id_RD;
  logic             id_use_rs, id_use_rt, id_RegWrt, id_mem, id_halt;
  logic             ex_branch, Done_DM;
  logic             NOP_mech, stall_fetch, flush_ifid, freeze, halted;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_RegWrt(id_RegWrt), .id_RD(id_RD), .id_mem(id_mem), .id_halt(id_halt),
    .ex_branch(ex_branch), .Done_DM(Done_DM),
    .NOP_mech(NOP_mech), .stall_fetch(stall_fetch), .flush_ifid(flush_ifid),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control vector: {NOP_mech, stall_fetch, flush_ifid, freeze, halted}
  function automatic logic [4:0] outs();
    return {NOP_mech, stall_fetch, flush_ifid, freeze, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; id_RD = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_RegWrt = 1'b0;
    id_mem = 1'b0; id_halt = 1'b0; ex_branch = 1'b0; Done_DM = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {id_rs, id_rt, id_RD} = 9'($urandom);
      {id_use_rs, id_use_rt, id_RegWrt, id_mem, id_halt, ex_branch, Done_DM} = 7'($urandom);
      tick();
    end
    rst = 1'b0;
    set_idle();
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    tick();
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL reset_idle got=%b exp=%b", outs(), 5'b00000); end
  endtask

  task automatic test_raw_ex();
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd3;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL raw_ex_prod got=%b exp=%b", outs(), 5'b00000); end
    tick();
    set_idle(); id_use_rs = 1'b1; id_rs = 3'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (outs() !== 5'b11000) begin bad++; $display("FAIL raw_ex_bubble%0d got=%b exp=%b", i, outs(), 5'b11000); end
      tick();
    end
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL raw_ex_release got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL raw_ex_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_raw_mem();
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd5;
    tick();
    id_RD = 3'd1; id_use_rs = 1'b1; id_rs = 3'd2;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL raw_mem_indep got=%b exp=%b", outs(), 5'b00000); end
    tick();
    set_idle(); id_use_rt = 1'b1; id_rt = 3'd5;
    #1;
    total++; if (outs() !== 5'b11000) begin bad++; $display("FAIL raw_mem_bubble got=%b exp=%b", outs(), 5'b11000); end
    tick();
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL raw_mem_release got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL raw_mem_cnt got=%0d exp=1", stall_cnt); end

    // Reader three slots behind the producer sees it only in WB: no bubble.
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd5;
    tick();
    id_RD = 3'd1;
    tick();
    id_RD = 3'd2;
    tick();
    set_idle(); id_use_rs = 1'b1; id_rs = 3'd5;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL raw_wb_bypass got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL raw_wb_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_branch_raw();
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd3;
    tick();
    set_idle(); id_use_rs = 1'b1; id_rs = 3'd3; ex_branch = 1'b1;
    #1;
    total++; if (outs() !== 5'b10100) begin bad++; $display("FAIL branch_over_raw got=%b exp=%b", outs(), 5'b10100); end
    tick();
    ex_branch = 1'b0;
    #1;
    total++; if (outs() !== 5'b11000) begin bad++; $display("FAIL branch_then_raw got=%b exp=%b", outs(), 5'b11000); end
    tick();
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL branch_raw_release got=%b exp=%b", outs(), 5'b00000); end
  endtask

  task automatic test_cache_miss();
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd6; id_mem = 1'b1;
    tick();
    set_idle();
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL miss_load_ex got=%b exp=%b", outs(), 5'b00000); end
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (outs() !== 5'b01010) begin bad++; $display("FAIL miss_freeze%0d got=%b exp=%b", i, outs(), 5'b01010); end
      tick();
    end
    Done_DM = 1'b1;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL miss_done got=%b exp=%b", outs(), 5'b00000); end
    tick();
    // Load now in WB (bypassed); MEM holds the bubble from behind it.
    Done_DM = 1'b0; id_use_rs = 1'b1; id_rs = 3'd6;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL miss_shift got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd6) begin bad++; $display("FAIL miss_cnt got=%0d exp=6", stall_cnt); end
  endtask

  task automatic test_branch_miss();
    apply_reset();
    id_RegWrt = 1'b1; id_RD = 3'd6; id_mem = 1'b1;
    tick();
    set_idle();
    tick();
    ex_branch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (outs() !== 5'b01010) begin bad++; $display("FAIL bmiss_freeze%0d got=%b exp=%b", i, outs(), 5'b01010); end
      tick();
    end
    Done_DM = 1'b1; id_RegWrt = 1'b1; id_RD = 3'd7;
    #1;
    total++; if (outs() !== 5'b10100) begin bad++; $display("FAIL bmiss_flush got=%b exp=%b", outs(), 5'b10100); end
    tick();
    // The squashed r7 writer must not have entered the scoreboard.
    set_idle(); id_use_rs = 1'b1; id_rs = 3'd7;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL bmiss_squash got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL bmiss_cnt got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_halt();
    apply_reset();
    id_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL halt_pending%0d got=%b exp=%b", i, outs(), 5'b00000); end
      tick();
      set_idle();
    end
    #1;
    total++; if (outs() !== 5'b01011) begin bad++; $display("FAIL halt_enter got=%b exp=%b", outs(), 5'b01011); end
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_branch = 1'b1; id_use_rs = 1'b1; Done_DM = 1'(i);
      #1;
      total++; if (outs() !== 5'b01011) begin bad++; $display("FAIL halt_hold%0d got=%b exp=%b", i, outs(), 5'b01011); end
    end
    set_idle();
    repeat ((1 << CNT_W) + 5) tick();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate got=%h exp=ffff", stall_cnt); end
    total++; if (outs() !== 5'b01011) begin bad++; $display("FAIL halt_long got=%b exp=%b", outs(), 5'b01011); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (outs() !== 5'b00000) begin bad++; $display("FAIL halt_reset got=%b exp=%b", outs(), 5'b00000); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL halt_reset_cnt got=%0d exp=0", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_raw_ex();
    test_raw_mem();
    test_branch_raw();
    test_cache_miss();
    test_branch_miss();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. It tracks the destination registers of the three instructions downstream of decode (EX, MEM, WB) in a scoreboard. From that it drives the decode-stage `NOP_mech` bubble, the PC/IF-ID hold, the IF-ID flush on taken branches, and the global freeze while the data cache is busy. It sits beside `decode` and owns every stall/flush decision.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs`  in  3  RS field of the instruction in ID (`instr[10:8]`).
- `id_rt`  in  3  RT field of the instruction in ID (`instr[7:5]`).
- `id_use_rs`  in  1  ID instruction reads RS.
- `id_use_rt`  in  1  ID instruction reads RT.
- `id_RegWrt`  in  1  ID instruction writes a register.
- `id_RD`  in  3  ID destination register.
- `id_mem`  in  1  ID instruction is a load or store.
- `id_halt`  in  1  ID instruction is HALT (`~nHaltSig`).
- `ex_branch`  in  1  branch/jump taken in EX (`NOP_Branch`).
- `Done_DM`  in  1  data memory has completed its access this cycle.
- `NOP_mech`  out  1  force the ID instruction to a NOP; it enters EX as a bubble.
- `stall_fetch`  out  1  hold PC and IF/ID.
- `flush_ifid`  out  1  replace IF/ID with NOP next edge.
- `freeze`  out  1  hold every pipeline register (ID/EX, EX/MEM, MEM/WB).
- `halted`  out  1  HALT has retired.
- `stall_cnt`  out  CNT_W  count of cycles with `stall_fetch`=1, saturating.

## Operation
- Scoreboard: three entries `{v, RD, mem, halt}` for EX, MEM and WB. On each unfrozen edge it shifts ID→EX→MEM→WB. The ID→EX entry is `{id_RegWrt & ~NOP_mech & ~ex_branch, id_RD, id_mem, id_halt}`; all fields are 0 when bubbled or flushed.
- The WB stage needs no stall because the register file bypasses its write.
- `raw` = (`id_use_rs` & match(id_rs)) | (`id_use_rt` & match(id_rt)), where match(r) = (EX.v & EX.RD==r) | (MEM.v & MEM.RD==r).
- `mem_busy` = MEM.mem & ~`Done_DM`.
- FSM states: RUN, MWAIT, HALT.
  - RUN → MWAIT when `mem_busy`.
  - MWAIT → RUN on the cycle `Done_DM`=1.
  - Any state except reset → HALT when WB.halt=1 on an edge.
  - HALT exits only on `rst`.
- Output priority is rst > HALT > mem_busy > ex_branch > raw.
  - HALT: `freeze`=`stall_fetch`=`halted`=1; the scoreboard is frozen.
  - mem_busy, in MWAIT or on the first busy cycle in RUN: `freeze`=`stall_fetch`=1, all else 0, scoreboard frozen. EX is frozen, so a pending `ex_branch` stays asserted and is acted on when the freeze drops.
  - ex_branch: `flush_ifid`=1 and `NOP_mech`=1 (the wrong-path ID instruction is squashed), `stall_fetch`=0. A coincident `raw` is ignored.
  - raw: `NOP_mech`=1, `stall_fetch`=1. The bubble shifts into EX and the condition re-evaluates every cycle.
  - Otherwise all outputs are 0.
- `stall_cnt` increments on each edge where `stall_fetch`=1 and holds at all-ones.

## Timing
- All control outputs are combinational from scoreboard state and current inputs, so they take effect at the next edge. The scoreboard, FSM and counter are registered.
- Reset, sampled on a `clk` edge with `rst`=1:
  - Scoreboard entries invalid; state RUN; `stall_cnt`=0.
  - The outputs then evaluate to all 0.
  - A reset during MWAIT or HALT returns to RUN in one cycle.
- A RAW hazard on an EX producer costs 2 bubbles. A hazard on a MEM producer costs 1.
- A `Done_DM` pulse of one cycle releases the freeze on that same cycle. MEM shifts to WB at that edge.
- `ex_branch` and `mem_busy` together: freeze wins and the flush is deferred.
- The ID instruction is never lost while `stall_fetch`=1.

## Test plan
- Reset values: hold `rst`=1 for 2 cycles with random inputs → all outputs 0 and `stall_cnt`=0 the cycle after `rst` drops.
- EX-producer RAW: ID `ADD r3` (RegWrt, RD=3), then ID reads rs=3 → `NOP_mech`=`stall_fetch`=1 for exactly 2 cycles, then 0; `stall_cnt`=2.
- MEM-producer RAW plus WB bypass: producer RD=5 followed by one independent instruction, then a reader of r5 → 1 bubble. A reader placed 3 slots behind the producer → 0 bubbles.
- Cache miss: load in MEM with `Done_DM` held low for 6 cycles → `freeze`=`stall_fetch`=1 for 6 cycles. On the 7th cycle `Done_DM`=1 → `freeze`=0, and the scoreboard shifts once.
- Branch during miss: `ex_branch`=1 while `mem_busy` for 3 cycles → `flush_ifid`=0 during the freeze. It pulses to 1 on the first unfrozen cycle, and `NOP_mech`=1 on that same cycle.
- HALT: HALT decoded → `halted`=1 exactly 3 unfrozen edges later. Outputs remain `freeze`=1 until `rst`. Counter saturation: hold a stall for 2^CNT_W+5 cycles → `stall_cnt`=0xFFFF.
